imm_pack: RTL

Pipelined immediate encoder for the 24-bit datapath. It is the inverse of the decode-stage zero-extender. It takes a full-width value and an ImmSrc selector, narrows the value into the immediate field of a 19-bit instruction payload, and flags values that do not survive the round trip. It sits in the instruction-construction path used by the loader and patch logic, and uses a valid/ready elastic handshake on both sides.

---
 rtl/imm_pack_pkg.sv | 41 ++++
 rtl/imm_pack_stage.sv | 46 ++++
 rtl/imm_pack.sv | 97 +++++++++
 3 files changed

// File: rtl/imm_pack_pkg.sv
// Shared ImmSrc encodings, payload geometry and field-width helpers for the
// immediate packer and the decode-stage zero-extender.
package imm_pack_pkg;

    localparam int IMM_N = 24;
    localparam int PAY_W = 19;

    localparam logic [1:0] IMM_SRC_11  = 2'b00;
    localparam logic [1:0] IMM_SRC_19  = 2'b01;
    localparam logic [1:0] IMM_SRC_7   = 2'b11;
    localparam logic [1:0] IMM_SRC_ILL = 2'b10;

    typedef struct packed {
        logic [PAY_W-1:0] imm_lo;
        logic [PAY_W-1:0] base;
        logic [PAY_W-1:0] mask;
        logic             ovf;
        logic             illegal;
    } s1_t;

    typedef struct packed {
        logic [PAY_W-1:0] field;
        logic             ovf;
        logic             illegal;
    } s2_t;

    function automatic int unsigned field_width(input logic [1:0] src);
        case (src)
            IMM_SRC_11: return 11;
            IMM_SRC_19: return 19;
            IMM_SRC_7:  return 7;
            default:    return 0;
        endcase
    endfunction

    // An illegal select yields an empty mask, so the base passes through untouched.
    function automatic logic [PAY_W-1:0] field_mask(input logic [1:0] src);
        return PAY_W'((32'd1 << field_width(src)) - 32'd1);
    endfunction

endpackage

// File: rtl/imm_pack_stage.sv
// Generic valid/ready pipeline register; loads when empty or when draining
// in the same cycle, so a full pipe streams one beat per clock.
module imm_pack_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        load    = in_valid & in_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/imm_pack.sv
// Two-stage immediate encoder: narrows a 24-bit value into the ImmSrc field of
// a 19-bit payload. Error-beat counter built only with IMM_PACK_ERRCNT_EN.
module imm_pack
    import imm_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_N-1:0] in_imm,
    input  logic [1:0]       in_immsrc,
    input  logic [PAY_W-1:0] in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] out_field,
    output logic             out_ovf,
    output logic             out_illegal,
    input  logic             err_clr,
    output logic [15:0]      err_count
);

    s1_t  s1_in, s1_q;
    s2_t  s2_in, s2_q;
    logic s1_valid, s2_in_ready;

    always_comb begin
        s1_in         = '0;
        s1_in.imm_lo  = in_imm[PAY_W-1:0];
        s1_in.base    = in_base;
        s1_in.mask    = field_mask(in_immsrc);
        s1_in.illegal = (in_immsrc == IMM_SRC_ILL);
        s1_in.ovf     = !s1_in.illegal &&
                        (|(in_imm & ~{{(IMM_N-PAY_W){1'b0}}, s1_in.mask}));
    end

    imm_pack_stage #(.W($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // Overflowing values still merge their truncated low bits.
    always_comb begin
        s2_in         = '0;
        s2_in.field   = s1_q.illegal ? s1_q.base
                      : ((s1_q.base & ~s1_q.mask) | (s1_q.imm_lo & s1_q.mask));
        s2_in.ovf     = s1_q.ovf;
        s2_in.illegal = s1_q.illegal;
    end

    imm_pack_stage #(.W($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_field   = s2_q.field;
    assign out_ovf     = s2_q.ovf;
    assign out_illegal = s2_q.illegal;

`ifdef IMM_PACK_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_fire;

    always_comb begin
        err_fire  = out_valid & out_ready & (out_ovf | out_illegal);
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_fire && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule
